// File: rtl/data_bus_bridge.sv
// ---------------------------------------------------------------------------
// data_bus_bridge
//
// Purpose:
//   Address decoder and data steering between the CPU's M-stage memory port,
//   the external data memory, and an embedded programmable countdown timer.
//   Load data returns combinationally in the same cycle. The timer raises a
//   registered interrupt request for the exception stage.
//
// Memory map (byte addresses):
//   [0, DM_LIMIT)              data memory
//   [TC_BASE, TC_BASE+11]      timer: +0 CTRL, +4 PRESET, +8 COUNT
//   anything else              unmapped (reads 0, writes dropped)
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-low reset
//   cpu_addr    CPU data byte address
//   cpu_wdata   CPU store data, lane-aligned
//   cpu_byteen  CPU byte write enables (0000 = no write)
//   cpu_rdata   load data to the CPU (combinational)
//   dm_addr     data memory address (always cpu_addr)
//   dm_wdata    data memory write data (always cpu_wdata)
//   dm_byteen   data memory byte enables (gated by the DM decode)
//   dm_rdata    data memory read data (combinational)
//   tc_irq      timer interrupt request (registered)
//
// Timer CTRL bits: [0] EN, [2:1] MODE (01 auto-reload, else one-shot),
//                  [3] IM (interrupt mask, 1 = irq visible on tc_irq).
// ---------------------------------------------------------------------------
module data_bus_bridge #(
    parameter logic [31:0] DM_LIMIT = 32'h0000_3000,
    parameter logic [31:0] TC_BASE  = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    output logic [31:0] cpu_rdata,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_byteen,
    input  logic [31:0] dm_rdata,
    output logic        tc_irq
);

    localparam logic [31:0] TC_LAST = TC_BASE + 32'd11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // ------------------------------------------------------------------
    // Timer state
    // ------------------------------------------------------------------
    logic [3:0]  ctrl_q,     ctrl_d;
    logic [31:0] preset_q,   preset_d;
    logic [31:0] count_q,    count_d;
    logic [1:0]  state_q,    state_d;
    logic        irq_flag_q, irq_flag_d;
    logic        tc_irq_q,   tc_irq_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       sel_dm;
    logic       sel_tc;
    logic [1:0] tc_off;
    logic       full_word;
    logic       wr_ctrl;
    logic       wr_preset;
    logic       auto_reload;

    assign sel_dm    = (cpu_addr < DM_LIMIT);
    assign sel_tc    = (cpu_addr >= TC_BASE) && (cpu_addr <= TC_LAST);
    assign tc_off    = cpu_addr[3:2];
    assign full_word = (cpu_byteen == 4'b1111);

    // Only full-word stores reach the timer; COUNT is read-only.
    assign wr_ctrl   = sel_tc && full_word && (tc_off == OFF_CTRL);
    assign wr_preset = sel_tc && full_word && (tc_off == OFF_PRESET);

    // MODE 1x falls back to one-shot.
    assign auto_reload = (ctrl_q[2:1] == 2'b01);

    // ------------------------------------------------------------------
    // Data memory path
    // ------------------------------------------------------------------
    assign dm_addr   = cpu_addr;
    assign dm_wdata  = cpu_wdata;
    assign dm_byteen = sel_dm ? cpu_byteen : 4'b0000;

    // ------------------------------------------------------------------
    // Load data mux
    // ------------------------------------------------------------------
    always_comb begin
        cpu_rdata = 32'd0;
        if (sel_dm) begin
            cpu_rdata = dm_rdata;
        end else if (sel_tc) begin
            case (tc_off)
                OFF_CTRL:   cpu_rdata = {28'd0, ctrl_q};
                OFF_PRESET: cpu_rdata = preset_q;
                OFF_COUNT:  cpu_rdata = count_q;
                default:    cpu_rdata = 32'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Timer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        state_d  = state_q;
        // In auto-reload the flag is a one-cycle pulse raised in INT; in
        // one-shot it holds until software rewrites CTRL. A mode change
        // always goes through a CTRL write, which clears the flag, so a
        // sticky flag can never leak into auto-reload mode.
        irq_flag_d = auto_reload ? 1'b0 : irq_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[0]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[0]) begin
                    // Disabled: freeze COUNT; the next enable reloads it.
                    state_d = ST_IDLE;
                end else if (count_q <= 32'd1) begin
                    // Covers PRESET=0, which then times out like PRESET=1.
                    count_d = 32'd0;
                    state_d = ST_INT;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            ST_INT: begin
                irq_flag_d = 1'b1;
                state_d    = ST_IDLE;
                if (!auto_reload) begin
                    ctrl_d[0] = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Software writes are applied last so they win over the automatic
        // EN clear in INT, and any accepted CTRL write clears the flag.
        if (wr_ctrl) begin
            ctrl_d     = cpu_wdata[3:0];
            irq_flag_d = 1'b0;
        end
        // PRESET only feeds COUNT in LOAD, so a write mid-count waits for
        // the next reload.
        if (wr_preset) begin
            preset_d = cpu_wdata;
        end

        // Built purely from flops: no CPU-input-to-irq combinational path.
        tc_irq_d = irq_flag_q & ctrl_q[3];
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            state_q    <= ST_IDLE;
            irq_flag_q <= 1'b0;
            tc_irq_q   <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            state_q    <= state_d;
            irq_flag_q <= irq_flag_d;
            tc_irq_q   <= tc_irq_d;
        end
    end

    assign tc_irq = tc_irq_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// ---------------------------------------------------------------------------
// tb_data_bus_bridge
//
// Bench for data_bus_bridge. Inputs are driven 1 time unit after each rising
// edge and outputs are sampled 1 unit later. A reference model of the timer
// steps on every rising edge; it tracks the timer as a position within its
// run (waiting, reload, counting step j, timeout) and derives COUNT as
// PRESET - j, rather than mirroring the design's registers.
// ---------------------------------------------------------------------------
module tb_data_bus_bridge;

    localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
    localparam logic [31:0] A_PRESET = 32'h0000_7F04;
    localparam logic [31:0] A_COUNT  = 32'h0000_7F08;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic [31:0] cpu_addr   = 32'd0;
    logic [31:0] cpu_wdata  = 32'd0;
    logic [3:0]  cpu_byteen = 4'd0;
    logic [31:0] dm_rdata   = 32'd0;
    logic [31:0] cpu_rdata;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_byteen;
    logic        tc_irq;

    always #5 clk = ~clk;

    data_bus_bridge dut (
        .clk        (clk),
        .reset      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_byteen (cpu_byteen),
        .cpu_rdata  (cpu_rdata),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_byteen  (dm_byteen),
        .dm_rdata   (dm_rdata),
        .tc_irq     (tc_irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [3:0]  m_ctrl   = 4'd0;
    logic [31:0] m_preset = 32'd0;
    logic [31:0] m_count  = 32'd0;
    logic        m_flag   = 1'b0;
    logic        m_irq    = 1'b0;
    logic [31:0] m_base   = 32'd0;   // PRESET captured at the last reload
    longint      m_len    = 0;       // counting steps in the current run
    longint      m_pos    = -1;      // -1 waiting, 0 reload, 1..len counting, len+1 timeout

    task automatic model_step();
        logic [3:0]  n_ctrl;
        logic [31:0] n_count;
        logic        n_flag;
        longint      n_pos;
        logic        auto_mode;
        logic        tc_hit;
        logic        full;
        if (!rst_n) begin
            m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0;
            m_flag = 1'b0; m_irq = 1'b0; m_base = 32'd0;
            m_len = 0; m_pos = -1;
            return;
        end
        auto_mode = (m_ctrl[2:1] == 2'b01);
        n_ctrl  = m_ctrl;
        n_count = m_count;
        n_pos   = m_pos;
        n_flag  = auto_mode ? 1'b0 : m_flag;
        if (m_pos < 0) begin
            if (m_ctrl[0]) n_pos = 0;
        end else if (m_pos == 0) begin
            m_base  = m_preset;
            m_len   = (m_preset == 32'd0) ? 1 : longint'(m_preset);
            n_count = m_preset;
            n_pos   = 1;
        end else if (m_pos <= m_len) begin
            if (!m_ctrl[0]) begin
                n_pos = -1;
            end else begin
                n_count = (longint'(m_base) > m_pos) ? 32'(longint'(m_base) - m_pos) : 32'd0;
                n_pos   = m_pos + 1;
            end
        end else begin
            n_pos  = -1;
            n_flag = 1'b1;
            if (!auto_mode) n_ctrl[0] = 1'b0;
        end
        m_irq  = m_flag & m_ctrl[3];
        tc_hit = (cpu_addr >= 32'h7F00) && (cpu_addr <= 32'h7F0B);
        full   = (cpu_byteen == 4'hF);
        if (tc_hit && full && cpu_addr[3:2] == 2'd0) begin
            n_ctrl = cpu_wdata[3:0];
            n_flag = 1'b0;
        end
        if (tc_hit && full && cpu_addr[3:2] == 2'd1) m_preset = cpu_wdata;
        m_ctrl  = n_ctrl;
        m_count = n_count;
        m_flag  = n_flag;
        m_pos   = n_pos;
    endtask

    always @(posedge clk) model_step();

    function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [31:0] d);
        if (a < 32'h3000) return d;
        if (a >= 32'h7F00 && a <= 32'h7F0B) begin
            case (a[3:2])
                2'd0:    return {28'd0, m_ctrl};
                2'd1:    return m_preset;
                2'd2:    return m_count;
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    // ------------------------------------------------------------------
    // Checking / driver tasks
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive, settle, compare everything against the model.
    task automatic cyc(input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] be, input logic [31:0] d);
        @(posedge clk);
        #1;
        cpu_addr   = a;
        cpu_wdata  = w;
        cpu_byteen = be;
        dm_rdata   = d;
        #1;
        chk("model_rdata", cpu_rdata, exp_read(a, d));
        chk("model_irq", 32'(tc_irq), 32'(m_irq));
        chk("dm_byteen", 32'(dm_byteen), (a < 32'h3000) ? 32'(be) : 32'd0);
        chk("dm_addr", dm_addr, a);
        chk("dm_wdata", dm_wdata, w);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] w);
        cyc(a, w, 4'hF, $urandom);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(a, 32'd0, 4'h0, $urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd(A_COUNT);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Vector table for decode / steering
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] dmr;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs [17];

    int oneshot_cnt [10] = '{0, 0, 5, 4, 3, 2, 1, 0, 0, 0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs = '{
            '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 32'h0000_0000, 4'hF},
            '{32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'h0},
            '{32'h0000_4000, 32'h1111_2222, 4'hF, 32'h5555_5555, 32'h0000_0000, 4'h0},
            '{32'h0000_4000, 32'h0000_0000, 4'h0, 32'h5555_5555, 32'h0000_0000, 4'h0},
            '{32'h0000_7F0C, 32'h0000_0000, 4'h0, 32'h5555_5555, 32'h0000_0000, 4'h0},
            '{32'h0000_2FFC, 32'h0000_BBCC, 4'h3, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'h3},
            '{32'h0000_3000, 32'h0000_0001, 4'hF, 32'h0000_0001, 32'h0000_0000, 4'h0},
            '{32'h0000_7F04, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h1234_5678, 4'h0},
            '{32'h0000_7F08, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 4'h0},
            '{32'h0000_7F00, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 4'h0},
            '{32'h0000_7EFC, 32'h0000_0009, 4'hF, 32'h0000_0007, 32'h0000_0000, 4'h0},
            '{32'h0000_7F07, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h1234_5678, 4'h0},
            '{32'h0000_7F04, 32'h0000_FFFF, 4'h3, 32'h0000_0000, 32'h1234_5678, 4'h0},
            '{32'h0000_7F04, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h1234_5678, 4'h0},
            '{32'h0000_7F08, 32'h0000_0099, 4'hF, 32'h0000_0000, 32'h0000_0000, 4'h0},
            '{32'h0000_7F08, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 4'h0},
            '{32'hFFFF_FFFC, 32'hCAFE_F00D, 4'hF, 32'h0BAD_0BAD, 32'h0000_0000, 4'h0}
        };

        // ---- reset state ----
        rd(A_CTRL);
        chk("reset_ctrl", cpu_rdata, 32'd0);
        chk("reset_irq", 32'(tc_irq), 32'd0);
        rst_n = 1'b1;
        rd(A_PRESET);
        chk("reset_preset", cpu_rdata, 32'd0);
        rd(A_COUNT);
        chk("reset_count", cpu_rdata, 32'd0);

        // ---- decode table ----
        wr(A_PRESET, 32'h1234_5678);
        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].dmr);
            chk("vec_rdata", cpu_rdata, vecs[i].exp_rdata);
            chk("vec_byteen", 32'(dm_byteen), 32'(vecs[i].exp_be));
        end

        // ---- one-shot, PRESET=5, IM on ----
        do_reset();
        wr(A_PRESET, 32'd5);
        wr(A_CTRL, 32'h9);
        for (int k = 0; k < 10; k++) begin
            rd(A_COUNT);
            chk("oneshot_count", cpu_rdata, 32'(oneshot_cnt[k]));
            chk("oneshot_irq", 32'(tc_irq), (k == 9) ? 32'd1 : 32'd0);
        end
        rd(A_CTRL);
        chk("oneshot_en_cleared", cpu_rdata, 32'h8);
        chk("oneshot_irq_sticky", 32'(tc_irq), 32'd1);
        rd(A_COUNT);
        chk("oneshot_irq_sticky2", 32'(tc_irq), 32'd1);
        wr(A_CTRL, 32'h0);
        rd(A_COUNT);
        rd(A_COUNT);
        chk("oneshot_irq_cleared", 32'(tc_irq), 32'd0);

        // ---- auto-reload, PRESET=3: 1-cycle pulse every 6 cycles ----
        do_reset();
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'hB);
        for (int k = 1; k <= 30; k++) begin
            rd(A_COUNT);
            chk("auto_irq", 32'(tc_irq), (k >= 8 && (k - 8) % 6 == 0) ? 32'd1 : 32'd0);
        end

        // ---- auto-reload with IM=0: never visible ----
        do_reset();
        wr(A_PRESET, 32'd3);
        wr(A_CTRL, 32'h3);
        for (int k = 1; k <= 30; k++) begin
            rd(A_COUNT);
            chk("masked_irq", 32'(tc_irq), 32'd0);
        end

        // ---- mid-count partial write, disable/freeze, re-enable, reset ----
        do_reset();
        wr(A_PRESET, 32'd10);
        wr(A_CTRL, 32'h1);
        rd(A_COUNT);
        rd(A_COUNT);
        rd(A_COUNT); chk("mid_count10", cpu_rdata, 32'd10);
        rd(A_COUNT); chk("mid_count9", cpu_rdata, 32'd9);
        rd(A_COUNT); chk("mid_count8", cpu_rdata, 32'd8);
        cyc(A_CTRL, 32'h0, 4'b0011, 32'd0);
        rd(A_COUNT); chk("partial_ignored6", cpu_rdata, 32'd6);
        rd(A_COUNT); chk("partial_ignored5", cpu_rdata, 32'd5);
        wr(A_CTRL, 32'h0);
        for (int k = 0; k < 3; k++) begin
            rd(A_COUNT);
            chk("frozen_count", cpu_rdata, 32'd3);
        end
        wr(A_CTRL, 32'h1);
        rd(A_COUNT); chk("reenable_idle", cpu_rdata, 32'd3);
        rd(A_COUNT); chk("reenable_load", cpu_rdata, 32'd3);
        rd(A_COUNT); chk("reenable_reloaded", cpu_rdata, 32'd10);
        rd(A_COUNT); chk("reenable_counting", cpu_rdata, 32'd9);
        do_reset();
        rd(A_COUNT);  chk("midreset_count", cpu_rdata, 32'd0);
        rd(A_PRESET); chk("midreset_preset", cpu_rdata, 32'd0);
        rd(A_CTRL);   chk("midreset_ctrl", cpu_rdata, 32'd0);
        chk("midreset_irq", 32'(tc_irq), 32'd0);

        // ---- CTRL write colliding with one-shot timeout ----
        do_reset();
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'h9);
        rd(A_COUNT);
        rd(A_COUNT);
        rd(A_COUNT); chk("collide_count2", cpu_rdata, 32'd2);
        rd(A_COUNT); chk("collide_count1", cpu_rdata, 32'd1);
        wr(A_CTRL, 32'h9);
        rd(A_CTRL);  chk("collide_en_kept", cpu_rdata, 32'h9);
        rd(A_COUNT); chk("collide_load", cpu_rdata, 32'd0);
        rd(A_COUNT); chk("collide_reloaded", cpu_rdata, 32'd2);

        // ---- randomized traffic against the model ----
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int unsigned op;
            logic [31:0] w;
            logic [31:0] a;
            logic [3:0]  be;
            op    = $urandom_range(0, 11);
            rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            case (op)
                0: wr(A_PRESET, 32'($urandom_range(0, 6)));
                1: begin
                    w = 32'($urandom_range(0, 15));
                    if ($urandom_range(0, 3) != 0) w[0] = 1'b1;
                    wr(A_CTRL, w);
                end
                2: begin
                    be = 4'($urandom_range(0, 14));
                    a  = ($urandom_range(0, 1) == 0) ? A_CTRL : A_PRESET;
                    cyc(a, $urandom, be, $urandom);
                end
                3: cyc(32'($urandom_range(0, 32'h2FFF)), $urandom, 4'($urandom_range(0, 15)), $urandom);
                4: cyc(32'h3000 + 32'($urandom_range(0, 32'h4EFF)), $urandom, 4'($urandom_range(0, 15)), $urandom);
                5: wr(A_COUNT, $urandom);
                6: begin
                    if ($urandom_range(0, 9) == 0) wr(A_PRESET, $urandom);
                    else rd(A_PRESET);
                end
                default: rd(A_CTRL + 32'(4 * $urandom_range(0, 3)));
            endcase
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
